// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer
// Frame-level controller between the UART receiver, the RGB-to-edge datapath
// and the UART transmitter.
//   - Parses a 4-byte big-endian header (W_hi, W_lo, H_hi, H_lo) and groups
//     the following byte stream into R,G,B pixels with first/last markers.
//   - Buffers edge-result bytes in a small FIFO and paces them into the
//     transmitter, at most one start every 3 cycles and only while idle.
//   - Reports rejected headers, inter-byte timeouts and result overflow.
//
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   rx_data_i, rx_valid_i             received byte + one-cycle strobe
//   pix_r_o/g_o/b_o, pix_valid_o      assembled pixel + strobe
//   pix_first_o, pix_last_o           frame position, qualify pix_valid_o
//   frame_w_o, frame_h_o              latched header dimensions
//   res_data_i, res_valid_i           edge-result byte + strobe
//   res_ready_o                       result FIFO not full
//   tx_data_o, tx_start_o, tx_busy_i  transmitter handshake
//   busy_o                            frame in progress (not in S_HDR)
//   frame_done_o, hdr_err_o           one-cycle status pulses
//   timeout_err_o                     one-cycle pulse on timeout abort
//   ovf_o                             sticky result-overflow flag
//
// state   | meaning
// S_HDR   | collecting the 4 header bytes
// S_PIX   | grouping bytes into pixels, idle timeout armed
// S_DRAIN | all pixels seen, waiting for the result stream to finish
module uart_frame_sequencer #(
    parameter int MAX_W          = 1024,
    parameter int MAX_H          = 1024,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  pix_r_o,
    output logic [7:0]  pix_g_o,
    output logic [7:0]  pix_b_o,
    output logic        pix_valid_o,
    output logic        pix_first_o,
    output logic        pix_last_o,
    output logic [15:0] frame_w_o,
    output logic [15:0] frame_h_o,
    input  logic [7:0]  res_data_i,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_busy_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        hdr_err_o,
    output logic        timeout_err_o,
    output logic        ovf_o
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] MAX_W_L   = 17'(MAX_W);
    localparam logic [16:0] MAX_H_L   = 17'(MAX_H);
    localparam logic [31:0] IDLE_LOAD = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_HDR, S_PIX, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [23:0] hdr_buf_q, hdr_buf_d;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  r_q, r_d, g_q, g_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] last_idx_q, last_idx_d;
    logic [31:0] idle_q, idle_d;
    logic [15:0] frame_w_q, frame_w_d, frame_h_q, frame_h_d;
    logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
    logic        pix_valid_q, pix_valid_d, pix_first_q, pix_first_d;
    logic        pix_last_q, pix_last_d, hdr_err_q, hdr_err_d;
    logic        timeout_q, timeout_d, frame_done_q, frame_done_d;
    logic        ovf_q, ovf_d;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [1:0]  st_hist_q;
    logic [7:0]  tx_data_q;
    logic        fifo_empty, fifo_full, push, pop, drain_ok;

    logic [15:0] w_new, h_new;
    logic        hdr_ok;

    assign w_new  = hdr_buf_q[23:8];
    assign h_new  = {hdr_buf_q[7:0], rx_data_i};
    assign hdr_ok = (w_new != 16'd0) && (h_new != 16'd0) &&
                    ({1'b0, w_new} <= MAX_W_L) && ({1'b0, h_new} <= MAX_H_L);

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push       = res_valid_i && !fifo_full;
    // st_hist_q remembers tx_start for the last two cycles; the transmitter
    // needs that long before its busy flag is trustworthy.
    assign pop        = !fifo_empty && !tx_busy_i && (st_hist_q == 2'b00);
    assign drain_ok   = fifo_empty && !tx_busy_i && (st_hist_q == 2'b00);

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        hdr_buf_d    = hdr_buf_q;
        ch_d         = ch_q;
        r_d          = r_q;
        g_d          = g_q;
        pix_cnt_d    = pix_cnt_q;
        last_idx_d   = last_idx_q;
        idle_d       = idle_q;
        frame_w_d    = frame_w_q;
        frame_h_d    = frame_h_q;
        pix_r_d      = pix_r_q;
        pix_g_d      = pix_g_q;
        pix_b_d      = pix_b_q;
        pix_valid_d  = 1'b0;
        pix_first_d  = 1'b0;
        pix_last_d   = 1'b0;
        hdr_err_d    = 1'b0;
        timeout_d    = 1'b0;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        case (state_q)
            S_HDR: begin
                if (rx_valid_i) begin
                    if (hdr_cnt_q == 2'd3) begin
                        hdr_cnt_d = 2'd0;
                        if (hdr_ok) begin
                            frame_w_d  = w_new;
                            frame_h_d  = h_new;
                            last_idx_d = 32'(w_new) * 32'(h_new) - 32'd1;
                            pix_cnt_d  = 32'd0;
                            ch_d       = 2'd0;
                            idle_d     = IDLE_LOAD;
                            ovf_d      = 1'b0;
                            state_d    = S_PIX;
                        end else begin
                            hdr_err_d = 1'b1;
                        end
                    end else begin
                        hdr_buf_d = {hdr_buf_q[15:0], rx_data_i};
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                    end
                end
            end
            S_PIX: begin
                if (rx_valid_i) begin
                    idle_d = IDLE_LOAD;
                    case (ch_q)
                        2'd0: begin
                            r_d  = rx_data_i;
                            ch_d = 2'd1;
                        end
                        2'd1: begin
                            g_d  = rx_data_i;
                            ch_d = 2'd2;
                        end
                        default: begin
                            pix_r_d     = r_q;
                            pix_g_d     = g_q;
                            pix_b_d     = rx_data_i;
                            pix_valid_d = 1'b1;
                            pix_first_d = (pix_cnt_q == 32'd0);
                            pix_last_d  = (pix_cnt_q == last_idx_q);
                            pix_cnt_d   = pix_cnt_q + 32'd1;
                            ch_d        = 2'd0;
                            if (pix_cnt_q == last_idx_q) begin
                                state_d = S_DRAIN;
                            end
                        end
                    endcase
                end else if (idle_q == 32'd0) begin
                    timeout_d = 1'b1;
                    ch_d      = 2'd0;
                    hdr_cnt_d = 2'd0;
                    state_d   = S_HDR;
                end else begin
                    idle_d = idle_q - 32'd1;
                end
            end
            S_DRAIN: begin
                if (drain_ok) begin
                    frame_done_d = 1'b1;
                    state_d      = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        // A dropped result byte wins over the clear at header accept.
        if (res_valid_i && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_HDR;
            hdr_cnt_q    <= 2'd0;
            hdr_buf_q    <= 24'd0;
            ch_q         <= 2'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            pix_cnt_q    <= 32'd0;
            last_idx_q   <= 32'd0;
            idle_q       <= 32'd0;
            frame_w_q    <= 16'd0;
            frame_h_q    <= 16'd0;
            pix_r_q      <= 8'd0;
            pix_g_q      <= 8'd0;
            pix_b_q      <= 8'd0;
            pix_valid_q  <= 1'b0;
            pix_first_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            hdr_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            hdr_buf_q    <= hdr_buf_d;
            ch_q         <= ch_d;
            r_q          <= r_d;
            g_q          <= g_d;
            pix_cnt_q    <= pix_cnt_d;
            last_idx_q   <= last_idx_d;
            idle_q       <= idle_d;
            frame_w_q    <= frame_w_d;
            frame_h_q    <= frame_h_d;
            pix_r_q      <= pix_r_d;
            pix_g_q      <= pix_g_d;
            pix_b_q      <= pix_b_d;
            pix_valid_q  <= pix_valid_d;
            pix_first_q  <= pix_first_d;
            pix_last_q   <= pix_last_d;
            hdr_err_q    <= hdr_err_d;
            timeout_q    <= timeout_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q      <= '0;
            rd_q      <= '0;
            st_hist_q <= 2'b00;
            tx_data_q <= 8'd0;
        end else begin
            st_hist_q <= {st_hist_q[0], pop};
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q      <= rd_q + 1'b1;
                tx_data_q <= fifo_mem[rd_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_q[AW-1:0]] <= res_data_i;
        end
    end

    // The popped byte is presented in the same cycle as tx_start and then
    // held by tx_data_q until the next pop.
    assign tx_data_o     = pop ? fifo_mem[rd_q[AW-1:0]] : tx_data_q;
    assign tx_start_o    = pop;
    assign res_ready_o   = !fifo_full;
    assign busy_o        = (state_q != S_HDR);
    assign pix_r_o       = pix_r_q;
    assign pix_g_o       = pix_g_q;
    assign pix_b_o       = pix_b_q;
    assign pix_valid_o   = pix_valid_q;
    assign pix_first_o   = pix_first_q;
    assign pix_last_o    = pix_last_q;
    assign frame_w_o     = frame_w_q;
    assign frame_h_o     = frame_h_q;
    assign hdr_err_o     = hdr_err_q;
    assign timeout_err_o = timeout_q;
    assign frame_done_o  = frame_done_q;
    assign ovf_o         = ovf_q;

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

Frame-level controller between the UART receiver, the RGB-to-edge datapath and the UART transmitter inside the top level. Parses the 4-byte frame header and groups the incoming byte stream into RGB pixels with start/end-of-frame markers. Buffers result bytes from the edge datapath and paces them into the transmitter. Also handles malformed headers, inter-byte timeouts and result overflow.

## Interface
- `MAX_W`, 1024: largest accepted frame width.
- `MAX_H`, 1024: largest accepted frame height.
- `FIFO_DEPTH`, 16: result FIFO entries, power of 2.
- `TIMEOUT_CYCLES`, 1_000_000: idle clocks allowed between bytes mid-frame.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `pix_r`, `pix_g`, `pix_b` out 8 each: assembled pixel.
- `pix_valid` out 1: one-cycle pixel strobe.
- `pix_first` out 1: qualifies `pix_valid`, first pixel of frame.
- `pix_last` out 1: qualifies `pix_valid`, last pixel of frame.
- `frame_w`, `frame_h` out 16 each: latched header dimensions.
- `res_data` in 8: edge-result byte.
- `res_valid` in 1: result strobe.
- `res_ready` out 1: FIFO not full.
- `tx_data` out 8: byte to transmitter.
- `tx_start` out 1: one-cycle transmit request.
- `tx_busy` in 1: transmitter busy.
- `busy` out 1: high outside `S_HDR`.
- `frame_done` out 1: one-cycle pulse.
- `hdr_err` out 1: one-cycle pulse on rejected header.
- `timeout_err` out 1: one-cycle pulse on timeout abort.
- `ovf` out 1: sticky result-overflow flag.

## Operation
- States: `S_HDR`, `S_PIX`, `S_DRAIN`.
- `S_HDR`: collect 4 bytes: W_hi, W_lo, H_hi, H_lo (big-endian).
  - Rejected if W==0, H==0, W>`MAX_W` or H>`MAX_H`: pulse `hdr_err`, header byte counter clears, stay in `S_HDR`.
  - Accepted: latch `frame_w`/`frame_h`, clear `ovf`, clear pixel count, enter `S_PIX`.
  - No timeout applies in `S_HDR`.
- `S_PIX`: channel counter 0→1→2 (R, G, B).
  - On the B byte, register the pixel and pulse `pix_valid`.
  - `pix_first` is asserted when pixel index is 0; `pix_last` when index is W*H−1.
  - Pixel count is 32 bits; the product is computed once at header accept.
  - After the last pixel, enter `S_DRAIN`.
  - `rx_valid` in `S_DRAIN` is ignored.
- Timeout: an idle counter resets on every `rx_valid`, active in `S_PIX` only.
  - Reaching `TIMEOUT_CYCLES`: pulse `timeout_err`, discard the partial pixel, go to `S_HDR`.
  - No `pix_last` is issued on timeout.
- `S_DRAIN`: when the FIFO is empty, `tx_busy`=0 and no `tx_start` occurred in the last 2 cycles, pulse `frame_done` and return to `S_HDR`.
- Result FIFO runs independently of state.
  - Push on `res_valid && res_ready`.
  - `res_valid` while full: byte dropped, `ovf` set; a same-cycle pop does not rescue it.
- TX pacing: pop and pulse `tx_start` when FIFO non-empty, `tx_busy`=0, and `tx_start` was not high in either of the previous 2 cycles (covers transmitter busy latency). `tx_data` holds the popped byte until the next pop.
- Reset: asynchronous, regardless of state.
  - State → `S_HDR`; all counters, the FIFO and `ovf` clear.
  - All outputs 0, except `res_ready`=1.

## Timing
- `rx_valid` on the B byte at cycle N → `pix_valid`, RGB, `pix_first`/`pix_last` at N+1, all registered.
- 4th header byte at cycle N → `frame_w`/`frame_h`, `busy`=1, or `hdr_err`, at N+1.
- Push at N → earliest `tx_start` at N+1 (FIFO non-empty, transmitter idle).
- Minimum `tx_start` spacing: 3 cycles; in practice set by `tx_busy`.
- `pix_valid` strobes are at least 3 `rx_valid` strobes apart; there is no backpressure toward the receiver.
- `frame_done` fires at least 1 cycle after `tx_busy` falls for the final byte.

## Test plan
- Header 00 03 00 02 + 18 bytes 01..12 → 6 `pix_valid`; the first carries RGB=01,02,03 with `pix_first`; the sixth carries 10,11,12 with `pix_last`; `frame_w`=3, `frame_h`=2.
- Header 00 00 00 05 → `hdr_err` pulse, `busy`=0. Then a valid header 00 02 00 02 is accepted.
- Valid header + 4 bytes, then idle `TIMEOUT_CYCLES` → `timeout_err`, no `pix_valid` for the partial pixel. A new frame then works.
- `tx_busy` held high, 17 `res_valid` bytes 00..10 → `res_ready`=0 after 16, `ovf`=1. After `tx_busy` is released: `tx_start` emits 00..0F in order, 0x10 never sent.
- 4 result bytes with a transmitter model that raises busy 1 cycle after start for 20 cycles → 4 `tx_start` pulses, none while busy. `frame_done` pulses after the last byte's busy falls.
- `reset` low mid-`S_PIX` → immediate `busy`=0, FIFO empty, `res_ready`=1. The next header is parsed from byte 0.
